// File: rtl/rr_grant_encoder.sv
// ============================================================================
// Module      : rr_grant_encoder
// Description : 15-requester round-robin arbiter with a programmable hold
//               limit, emitting a registered 4-bit grant code (0 = none).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_grant_encoder #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [14:0] req,
    output logic [3:0]  code,
    output logic        active,
    output logic [7:0]  hold_cnt
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;
    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);
    localparam logic [3:0] c_last_idx = 4'd14;

    logic [0:0] r_state;
    logic [3:0] r_last;
    logic [3:0] r_code;
    logic       r_active;
    logic [7:0] r_hold_cnt;

    logic [0:0] w_next_state;
    logic [3:0] w_next_last;
    logic [3:0] w_next_code;
    logic       w_next_active;
    logic [7:0] w_next_hold_cnt;

    logic [3:0] w_start;
    logic [4:0] w_idx;
    logic       w_found;
    logic [3:0] w_win;
    logic       w_keep;

    // Search begins one past the last winner, so the last winner ranks lowest
    // but is still reachable at the end of the scan (lone-requester timeout).
    always_comb begin
        w_start = (r_last == c_last_idx) ? 4'd0 : r_last + 4'd1;
        w_idx   = 5'd0;
        w_found = 1'b0;
        w_win   = 4'd0;
        for (int k = 0; k < 15; k++) begin
            w_idx = {1'b0, w_start} + 5'(k);
            if (w_idx >= 5'd15) begin
                w_idx = w_idx - 5'd15;
            end
            if (!w_found && req[w_idx[3:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[3:0];
            end
        end
    end

    assign w_keep = req[r_last] && ((c_max_hold == 8'd0) || (r_hold_cnt < c_max_hold));

    always_comb begin
        w_next_state    = r_state;
        w_next_last     = r_last;
        w_next_code     = r_code;
        w_next_active   = r_active;
        w_next_hold_cnt = r_hold_cnt;

        case (r_state)
            c_st_idle: begin
                w_next_code     = 4'd0;
                w_next_active   = 1'b0;
                w_next_hold_cnt = 8'd0;
                if (en && w_found) begin
                    w_next_state    = c_st_grant;
                    w_next_last     = w_win;
                    w_next_code     = w_win + 4'd1;
                    w_next_active   = 1'b1;
                    w_next_hold_cnt = 8'd1;
                end
            end
            c_st_grant: begin
                if (!en) begin
                    w_next_state    = c_st_idle;
                    w_next_code     = 4'd0;
                    w_next_active   = 1'b0;
                    w_next_hold_cnt = 8'd0;
                end else if (w_keep) begin
                    if (r_hold_cnt != 8'hFF) begin
                        w_next_hold_cnt = r_hold_cnt + 8'd1;
                    end
                end else if (w_found) begin
                    // Covers both timeout and release; on timeout the owner
                    // itself is the fallback winner when nobody else asks.
                    w_next_last     = w_win;
                    w_next_code     = w_win + 4'd1;
                    w_next_active   = 1'b1;
                    w_next_hold_cnt = 8'd1;
                end else begin
                    w_next_state    = c_st_idle;
                    w_next_code     = 4'd0;
                    w_next_active   = 1'b0;
                    w_next_hold_cnt = 8'd0;
                end
            end
            default: begin
                w_next_state    = c_st_idle;
                w_next_code     = 4'd0;
                w_next_active   = 1'b0;
                w_next_hold_cnt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_last     <= c_last_idx;
            r_code     <= 4'd0;
            r_active   <= 1'b0;
            r_hold_cnt <= 8'd0;
        end else begin
            r_state    <= w_next_state;
            r_last     <= w_next_last;
            r_code     <= w_next_code;
            r_active   <= w_next_active;
            r_hold_cnt <= w_next_hold_cnt;
        end
    end

    assign code     = r_code;
    assign active   = r_active;
    assign hold_cnt = r_hold_cnt;

endmodule

`default_nettype wire

// File: doc/rr_grant_encoder.md
Name: rr_grant_encoder

Overview:
- Round-robin arbiter for 15 requesters, emitting a registered 4-bit grant code.
- Grant code convention:
  - 4'd0 = no grant.
  - 4'dk (k=1..15) = requester k-1 granted.
- Sits directly upstream of the 4-to-16 one-hot decoder and drives its 4-bit select input. The decoder output is the one-hot grant bus.
- Holds a grant while the owner keeps requesting, up to a programmable hold limit.

Parameters:
- MAX_HOLD, default 8: maximum consecutive cycles one requester may hold the grant. 0 = unlimited. Legal range 0..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  arbitration enable. Low = no new grants; current grant is dropped.
- req  input  15  request vector; req[i] = requester i.
- code  output  4  registered grant code; 0 = none, i+1 = requester i.
- active  output  1  registered; 1 exactly when code != 0.
- hold_cnt  output  8  registered; cycles the current grant has been held (1 on first grant cycle). 0 when idle.

Behaviour:
- All state updates on the rising edge of clk. rst has priority over everything.
- Reset values:
  - code = 0, active = 0, hold_cnt = 0.
  - State = IDLE.
  - Internal last-granted index = 14, so the first search starts at index 0.
- Search function: starting at (last+1) mod 15, scan indices ascending and wrapping. The first i with req[i]=1 wins. Index 14 wraps to 0.
- IDLE:
  - en=1 and req!=0: winner w. Next edge: code=w+1, active=1, hold_cnt=1, last=w, go to GRANT.
  - Otherwise: stay in IDLE, outputs stay 0.
  - Latency is one cycle from the sampled request to code.
- GRANT, owner c, evaluated every edge in this priority order:
  1. en=0: next edge code=0, active=0, hold_cnt=0, go to IDLE. last stays c.
  2. req[c]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD): keep the grant. hold_cnt increments, saturating at 255.
  3. req[c]=1 and hold_cnt=MAX_HOLD (timeout): search from c+1.
     - Another requester w found: code=w+1, hold_cnt=1, last=w.
     - Only c is requesting: c is re-granted, hold_cnt=1. code is unchanged.
  4. req[c]=0 (release): search from c+1.
     - w found: code=w+1 on the next edge with no idle bubble, hold_cnt=1, last=w.
     - None found: code=0, active=0, hold_cnt=0, go to IDLE.
- Fairness: after granting w, w is the lowest-priority index in the next search. Any continuously asserted request is granted within 14 grant turns.
- Simultaneous events:
  - Release and new requests in the same cycle: the new requests are eligible immediately.
  - rst with anything: reset wins.
  - en falling in the same cycle as a timeout: drop the grant, per priority 1.
- Reset mid-grant: code=0 on the edge where rst is sampled high. The next grant search starts from index 0.
- code is always in 0..15. active must equal (code!=0) on every cycle.
- No combinational path from req or en to any output.

Test Plan:
- Reset, then req=15'h0001, en=1 -> code=1, active=1 one cycle after req is sampled. hold_cnt counts 1,2,…; code stays 1.
- MAX_HOLD=8, req=15'h0005 held constant -> code=1 for 8 cycles, then 3 for 8 cycles, then 1 again. hold_cnt restarts at 1 on each switch.
- Owner 14 granted (code=15), req changes to 15'h4001, then bit 14 drops -> next edge code=1, showing wrap 14→0. When bit 0 drops with req=0 -> code=0, active=0.
- Only requester 5 requesting, MAX_HOLD=8 -> code stays 6 across the timeout and hold_cnt goes 8→1. MAX_HOLD=0 -> hold_cnt saturates at 255 and the grant never rotates.
- Grant active (code=4), drive en=0 for one cycle -> next edge code=0. With en=1 and req[3] still set -> search starts at index 4. Req bits 3 and 7 both set -> code=8.
- rst asserted while code=10 -> code=0, active=0, hold_cnt=0 on that edge. Then req=15'h7FFF -> code=1 first, then 2, 3, … as each owner releases.
